// File: rtl/mix_sequencer_if.sv
// rtl/mix_sequencer_if.sv - memory port and datapath handshake bundle of the MIX sequencer
interface mix_sequencer_if #(
   parameter int AW = 12,
   parameter int WW = 31
);
   logic [AW-1:0] mem_addr;
   logic [WW-1:0] mem_rdata;
   logic          mem_we;
   logic [WW-1:0] st_wdata;
   logic [2:0]    idx_sel;
   logic [AW:0]   idx_val;
   logic [WW-1:0] ir;
   logic [AW-1:0] ea;
   logic          exec_strobe;
   logic          exec_busy;
   logic          jmp_cond;
   logic          j_we;
   logic [AW-1:0] j_val;

   modport master (
      output mem_addr, mem_we, idx_sel, ir, ea, exec_strobe, j_we, j_val,
      input  mem_rdata, st_wdata, idx_val, exec_busy, jmp_cond
   );

   modport slave (
      input  mem_addr, mem_we, idx_sel, ir, ea, exec_strobe, j_we, j_val,
      output mem_rdata, st_wdata, idx_val, exec_busy, jmp_cond
   );
endinterface

// File: rtl/mix_sequencer.sv
// rtl/mix_sequencer.sv - MIX instruction sequencer: fetch, indexed address, execute/store strobes
module mix_sequencer #(
   parameter int AW = 12,
   parameter int WW = 31
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           go,
   input  logic [AW-1:0]  start_pc,
   mix_sequencer_if.master bus,
   output logic [AW-1:0]  pc,
   output logic           halted,
   output logic           fault
);
   localparam int SW = AW + 2;

   typedef enum logic [2:0] {
      S_HALT, S_FETCH, S_DECODE, S_INDEX, S_OPERAND, S_EXEC, S_WRITE, S_FAULT
   } state_t;

   state_t state_q, state_d;
   logic [AW-1:0] pc_q, ea_q, pc_inc;
   logic [WW-1:0] ir_q;
   logic          exec_first;

   logic [5:0] op_c, op_f, op_i;
   logic signed [SW-1:0] aa_mag, ix_mag, aa_s, ix_s, sum_s;
   logic is_nop, is_hlt, is_jmp, is_opnd, is_store, is_imm;
   logic idx_bad, jump_taken;

   assign op_c   = ir_q[5:0];
   assign op_f   = ir_q[11:6];
   assign op_i   = ir_q[17:12];
   assign pc_inc = pc_q + AW'(1);

   // Both addends are sign-magnitude; -0 negates to 0, so it needs no special case.
   assign aa_mag = $signed({2'b00, ir_q[29:18]});
   assign ix_mag = $signed({2'b00, bus.idx_val[AW-1:0]});
   assign aa_s   = ir_q[30] ? -aa_mag : aa_mag;
   assign ix_s   = (op_i == 6'd0) ? '0 : (bus.idx_val[AW] ? -ix_mag : ix_mag);
   assign sum_s  = aa_s + ix_s;

   assign is_nop   = (op_c == 6'd0);
   assign is_hlt   = (op_c == 6'd5) && (op_f == 6'd2);
   assign is_jmp   = (op_c == 6'd39);
   assign is_opnd  = ((op_c >= 6'd1) && (op_c <= 6'd4)) ||
                     ((op_c >= 6'd8) && (op_c <= 6'd23)) || (op_c >= 6'd56);
   assign is_store = (op_c >= 6'd24) && (op_c <= 6'd33);
   assign is_imm   = (op_c >= 6'd48) && (op_c <= 6'd55);

   // Negative sums set the top bit, sums above 4095 set bit AW.
   assign idx_bad = sum_s[SW-1] || sum_s[AW] || (op_i > 6'd6) ||
                    !(is_nop || is_hlt || is_jmp || is_opnd || is_store || is_imm);
   assign jump_taken = (op_f == 6'd0) || (op_f == 6'd1) || bus.jmp_cond;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_HALT;
         pc_q       <= '0;
         ir_q       <= '0;
         ea_q       <= '0;
         exec_first <= 1'b0;
      end else begin
         state_q    <= state_d;
         exec_first <= (state_q != S_EXEC);
         case (state_q)
            S_HALT, S_FAULT: if (go) pc_q <= start_pc;
            S_DECODE: ir_q <= bus.mem_rdata;
            S_INDEX: begin
               ea_q <= sum_s[AW-1:0];
               if (!idx_bad && (is_nop || is_hlt || is_jmp))
                  pc_q <= (is_jmp && jump_taken) ? sum_s[AW-1:0] : pc_inc;
            end
            S_EXEC: if (!bus.exec_busy && !is_store) pc_q <= pc_inc;
            S_WRITE: pc_q <= pc_inc;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HALT, S_FAULT: if (go) state_d = S_FETCH;
         S_FETCH:   state_d = S_DECODE;
         S_DECODE:  state_d = S_INDEX;
         S_INDEX: begin
            if (idx_bad)                 state_d = S_FAULT;
            else if (is_hlt)             state_d = S_HALT;
            else if (is_nop || is_jmp)   state_d = S_FETCH;
            else if (is_opnd || is_store) state_d = S_OPERAND;
            else                         state_d = S_EXEC;
         end
         S_OPERAND: state_d = S_EXEC;
         // A multi-cycle datapath raises exec_busy alongside the strobe to hold EXEC.
         S_EXEC:    if (!bus.exec_busy) state_d = is_store ? S_WRITE : S_FETCH;
         S_WRITE:   state_d = S_FETCH;
         default:   state_d = S_HALT;
      endcase
   end

   always_comb begin
      bus.mem_addr    = pc_q;
      bus.mem_we      = 1'b0;
      bus.idx_sel     = 3'd0;
      bus.exec_strobe = 1'b0;
      bus.j_we        = 1'b0;
      bus.j_val       = pc_inc;
      case (state_q)
         S_OPERAND: bus.mem_addr = ea_q;
         S_WRITE: begin
            bus.mem_addr = ea_q;
            bus.mem_we   = !reset;
         end
         S_INDEX: begin
            bus.idx_sel = (op_i <= 6'd6) ? op_i[2:0] : 3'd0;
            bus.j_we    = !idx_bad && is_jmp && jump_taken && (op_f != 6'd1);
         end
         S_EXEC: bus.exec_strobe = exec_first;
         default: ;
      endcase
   end

   assign bus.ir = ir_q;
   assign bus.ea = ea_q;
   assign pc     = pc_q;
   assign halted = (state_q == S_HALT);
   assign fault  = (state_q == S_FAULT);
endmodule

// File: tb/tb_mix_sequencer.sv
// tb/tb_mix_sequencer.sv - scoreboard bench for mix_sequencer
module tb_mix_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        go = 1'b0;
   logic [11:0] start_pc = '0;
   logic [11:0] pc;
   logic        halted, fault;

   logic        load_img = 1'b1;
   logic        jmp_cond_v = 1'b0;
   int          busy_len = 0;
   int          busy_cnt = 0;
   logic [18:0] tag = 19'h1ABCD;
   logic [30:0] mem [4096];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          kind;
      int          a;
      logic [30:0] d;
      bit          chk_d;
   } ev_t;
   ev_t exp_q[$];

   localparam int EV_EXEC = 1, EV_WE = 2, EV_JWE = 3;
   localparam logic [30:0] D1 = 31'h1234567, D2 = 31'h0FEDCBA, D3 = 31'h2468ACE;

   mix_sequencer_if bus();

   mix_sequencer dut (
      .clk(clk), .reset(reset), .go(go), .start_pc(start_pc),
      .bus(bus), .pc(pc), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   function automatic logic [30:0] mk(input logic s, input int aa, input int i, input int f, input int c);
      return {s, aa[11:0], i[5:0], f[5:0], c[5:0]};
   endfunction

   // I1=+5, I2=-3; selector 0 returns junk that must be ignored.
   assign bus.idx_val  = (bus.idx_sel == 3'd1) ? 13'd5 :
                         (bus.idx_sel == 3'd2) ? {1'b1, 12'd3} : 13'd77;
   assign bus.st_wdata = {bus.ea, tag};
   assign bus.jmp_cond = jmp_cond_v;
   assign bus.exec_busy = (bus.exec_strobe && busy_len > 0) || (busy_cnt != 0);

   always @(posedge clk) begin
      if (bus.exec_strobe && busy_len > 1) busy_cnt <= busy_len - 1;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   always @(posedge clk) begin
      if (load_img) begin
         for (int a = 0; a < 4096; a++) mem[a] <= '0;
         mem[1]   <= mk(0, 0, 0, 2, 5);
         mem[20]  <= mk(0, 100, 1, 5, 8);
         mem[21]  <= mk(0, 100, 2, 5, 8);
         mem[22]  <= mk(0, 0, 0, 2, 5);
         mem[105] <= D1;
         mem[97]  <= D3;
         mem[30]  <= mk(0, 200, 0, 5, 24);
         mem[31]  <= mk(0, 0, 0, 2, 5);
         mem[200] <= D2;
         mem[10]  <= mk(0, 300, 0, 0, 39);
         mem[300] <= mk(0, 7, 0, 2, 48);
         mem[301] <= mk(0, 400, 0, 2, 39);
         mem[302] <= mk(0, 0, 0, 2, 5);
         mem[400] <= mk(0, 0, 0, 2, 5);
         mem[40]  <= mk(1, 5, 0, 5, 8);
         mem[41]  <= mk(0, 10, 7, 5, 8);
         mem[42]  <= mk(0, 4095, 1, 5, 8);
         mem[43]  <= mk(0, 0, 0, 0, 6);
         mem[44]  <= mk(0, 0, 0, 0, 5);
         mem[45]  <= mk(0, 2, 2, 2, 48);
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.st_wdata;
      end
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic check(input string tag_s, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag_s, got, exp);
      end
   endtask

   task automatic push(input int kind, input int a, input logic [30:0] d, input bit cd);
      ev_t e;
      e.kind = kind; e.a = a; e.d = d; e.chk_d = cd;
      exp_q.push_back(e);
   endtask

   task automatic got_ev(input int kind, input int a, input logic [30:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         check("sb_unexpected", kind, 0);
      end else begin
         e = exp_q.pop_front();
         check("sb_kind", kind, e.kind);
         check("sb_addr", a, e.a);
         if (e.chk_d) check("sb_data", {1'b0, d}, {1'b0, e.d});
      end
   endtask

   always @(negedge clk) begin
      if (bus.exec_strobe) got_ev(EV_EXEC, int'(bus.ea), bus.mem_rdata);
      if (bus.mem_we)      got_ev(EV_WE, int'(bus.mem_addr), bus.st_wdata);
      if (bus.j_we)        got_ev(EV_JWE, int'(bus.j_val), '0);
   end

   // Leaves the bench at the negedge of cycle 1, the first cycle after go is taken.
   task automatic go_pulse(input int a);
      @(negedge clk);
      start_pc = a[11:0];
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input int start, output int cyc);
      cyc = start;
      while (!(halted || fault) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      if (!(halted || fault)) check("timeout", 0, 1);
   endtask

   int cyc;
   int fault_pc [6] = '{40, 41, 42, 43, 44, 45};

   initial begin
      repeat (3) @(negedge clk);
      load_img = 1'b0;
      reset = 1'b0;
      check("rst_halted", halted, 1);
      check("rst_fault", fault, 0);
      check("rst_pc", pc, 0);
      check("rst_ir", bus.ir, 0);
      check("rst_ea", bus.ea, 0);
      check("rst_strobes", {bus.mem_we, bus.exec_strobe, bus.j_we}, 0);
      check("rst_idx_sel", bus.idx_sel, 0);
      check("rst_mem_addr", bus.mem_addr, 0);

      // NOP then HLT
      go_pulse(0);
      check("t1_fetch0", bus.mem_addr, 0);
      repeat (3) @(negedge clk);
      check("t1_fetch1", bus.mem_addr, 1);
      repeat (2) @(negedge clk);
      check("t1_not_yet_halted", halted, 0);
      @(negedge clk);
      check("t1_halted", halted, 1);
      check("t1_pc", pc, 2);

      // indexed loads: 100+5 and 100-3
      push(EV_EXEC, 105, D1, 1);
      push(EV_EXEC, 97, D3, 1);
      go_pulse(20);
      repeat (2) @(negedge clk);
      check("t2_idx_sel", bus.idx_sel, 1);
      @(negedge clk);
      check("t2_operand_addr", bus.mem_addr, 105);
      check("t2_ea", bus.ea, 105);
      @(negedge clk);
      check("t2_strobe", bus.exec_strobe, 1);
      @(negedge clk);
      check("t2_next_fetch", bus.mem_addr, 21);
      wait_done(6, cyc);
      check("t2_cycles", cyc, 14);
      check("t2_pc", pc, 23);

      // store
      push(EV_EXEC, 200, D2, 1);
      push(EV_WE, 200, {12'd200, tag}, 1);
      go_pulse(30);
      repeat (4) @(negedge clk);
      check("t3_we_c5", bus.mem_we, 0);
      @(negedge clk);
      check("t3_we_c6", bus.mem_we, 1);
      check("t3_we_addr", bus.mem_addr, 200);
      @(negedge clk);
      check("t3_we_c7", bus.mem_we, 0);
      wait_done(7, cyc);
      check("t3_cycles", cyc, 10);
      check("t3_pc", pc, 32);
      check("t3_mem", {1'b0, mem[200]}, {1'b0, 12'd200, 19'h1ABCD});

      // JMP 300, ENTA 7, JOV not taken, HLT
      jmp_cond_v = 1'b0;
      push(EV_JWE, 11, '0, 0);
      push(EV_EXEC, 7, '0, 0);
      go_pulse(10);
      repeat (2) @(negedge clk);
      check("t4_j_we", bus.j_we, 1);
      check("t4_j_val", bus.j_val, 11);
      @(negedge clk);
      check("t4_fetch300", bus.mem_addr, 300);
      wait_done(4, cyc);
      check("t4_cycles", cyc, 14);
      check("t4_pc", pc, 303);

      // JOV taken
      jmp_cond_v = 1'b1;
      push(EV_JWE, 302, '0, 0);
      go_pulse(301);
      wait_done(1, cyc);
      check("t4b_cycles", cyc, 7);
      check("t4b_pc", pc, 401);
      jmp_cond_v = 1'b0;

      // faults: negative, I=7, >4095, unsupported C, C=5 F!=2, negative via index
      foreach (fault_pc[k]) begin
         go_pulse(fault_pc[k]);
         repeat (3) @(negedge clk);
         check("t5_fault", fault, 1);
         check("t5_halted", halted, 0);
         check("t5_pc", pc, fault_pc[k]);
         check("t5_mem_addr", bus.mem_addr, fault_pc[k]);
      end
      repeat (3) @(negedge clk);
      check("t5_fault_sticky", fault, 1);
      go_pulse(0);
      check("t5_fault_cleared", fault, 0);
      wait_done(1, cyc);
      check("t5_resume_pc", pc, 2);

      // 3-cycle stall on the first load only
      busy_len = 3;
      push(EV_EXEC, 105, D1, 1);
      push(EV_EXEC, 97, D3, 1);
      go_pulse(20);
      repeat (4) @(negedge clk);
      check("t6_strobe", bus.exec_strobe, 1);
      @(negedge clk);
      busy_len = 0;
      check("t6_strobe_once", bus.exec_strobe, 0);
      repeat (3) @(negedge clk);
      check("t6_fetch_delayed", bus.mem_addr, 21);
      wait_done(9, cyc);
      check("t6_cycles", cyc, 17);

      // pc wrap
      go_pulse(4095);
      check("t6_fetch4095", bus.mem_addr, 4095);
      repeat (3) @(negedge clk);
      check("t6_fetch_wrap", bus.mem_addr, 0);
      wait_done(4, cyc);
      check("t6_wrap_cycles", cyc, 10);

      // reset in WRITE suppresses the store
      tag = 19'h00F0F;
      push(EV_EXEC, 200, {12'd200, 19'h1ABCD}, 1);
      go_pulse(30);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("t6_rst_we", bus.mem_we, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("t6_rst_halted", halted, 1);
      check("t6_rst_pc", pc, 0);
      check("t6_rst_mem", {1'b0, mem[200]}, {1'b0, 12'd200, 19'h1ABCD});

      repeat (2) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
